// File: rtl/br_puf_pkg.sv
// Shared types and defaults for the bistable-ring PUF reader.
// Holds the controller state encoding, default sizing and the vote-counter width helper.
package br_puf_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RST,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam int DEF_CHAL_W        = 32;
   localparam int DEF_RESP_W        = 32;
   localparam int DEF_RESET_CYCLES  = 8;
   localparam int DEF_SETTLE_CYCLES = 64;
   localparam int DEF_NUM_EVAL      = 5;

   // Enough bits to count every evaluation of a single ring.
   function automatic int vote_width(input int num_eval);
      return $clog2(num_eval + 1);
   endfunction

endpackage

// File: rtl/br_puf_sync.sv
// Free-running two-flop synchronizer for the asynchronous ring outputs.
// There is deliberately no reset, so sampling is never gated by reset_n.
module br_puf_sync #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      meta <= d;
      q    <= meta;
   end

endmodule

// File: rtl/br_puf_reader.sv
// Bistable-ring PUF reader: reset/settle/sample the ring array NUM_EVAL times, then majority-vote.
// Optional unanimity output stable_mask is enabled with `define BR_PUF_STABILITY_MASK_EN.
module br_puf_reader
   import br_puf_pkg::*;
#(
   parameter int CHAL_W        = DEF_CHAL_W,
   parameter int RESP_W        = DEF_RESP_W,
   parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int NUM_EVAL      = DEF_NUM_EVAL
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [CHAL_W-1:0] challenge,
   output logic              busy,
   output logic [RESP_W-1:0] response,
   output logic              response_valid,
   output logic [CHAL_W-1:0] puf_challenge,
   output logic              puf_reset,
   input  logic [RESP_W-1:0] puf_response
`ifdef BR_PUF_STABILITY_MASK_EN
   ,
   output logic [RESP_W-1:0] stable_mask
`endif
);

   localparam int VW = vote_width(NUM_EVAL);
   localparam logic [VW-1:0] HALF_VOTES = VW'(NUM_EVAL / 2);
`ifdef BR_PUF_STABILITY_MASK_EN
   localparam logic [VW-1:0] ALL_VOTES  = VW'(NUM_EVAL);
`endif

   state_t            state;
   logic [15:0]       cyc_cnt;
   logic [3:0]        eval_cnt;
   logic [VW-1:0]     vote [RESP_W];
   logic [RESP_W-1:0] resp_sync;
   logic              accept;

   br_puf_sync #(
      .WIDTH(RESP_W)
   ) u_sync (
      .clk(clk),
      .d  (puf_response),
      .q  (resp_sync)
   );

   assign accept = (state == IDLE) && !busy && start;

   // busy lags the state by one cycle, so it covers the response_valid cycle and
   // a held start is only re-accepted once busy has dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         cyc_cnt        <= '0;
         eval_cnt       <= '0;
         busy           <= 1'b0;
         response       <= '0;
         response_valid <= 1'b0;
         puf_challenge  <= '0;
         puf_reset      <= 1'b1;
         for (int i = 0; i < RESP_W; i++) vote[i] <= '0;
`ifdef BR_PUF_STABILITY_MASK_EN
         stable_mask    <= '0;
`endif
      end else begin
         response_valid <= 1'b0;
         busy           <= (state != IDLE);
         case (state)
            IDLE: begin
               puf_reset <= 1'b1;
               if (accept) begin
                  puf_challenge <= challenge;
                  cyc_cnt       <= '0;
                  eval_cnt      <= '0;
                  for (int i = 0; i < RESP_W; i++) vote[i] <= '0;
                  state         <= RST;
               end
            end
            RST: begin
               if (cyc_cnt == 16'(RESET_CYCLES - 1)) begin
                  cyc_cnt   <= '0;
                  puf_reset <= 1'b0;
                  state     <= SETTLE;
               end else begin
                  cyc_cnt <= cyc_cnt + 16'd1;
               end
            end
            SETTLE: begin
               if (cyc_cnt == 16'(SETTLE_CYCLES - 1)) begin
                  cyc_cnt <= '0;
                  state   <= SAMPLE;
               end else begin
                  cyc_cnt <= cyc_cnt + 16'd1;
               end
            end
            SAMPLE: begin
               for (int i = 0; i < RESP_W; i++) vote[i] <= vote[i] + VW'(resp_sync[i]);
               eval_cnt  <= eval_cnt + 4'd1;
               puf_reset <= 1'b1;
               state     <= (eval_cnt == 4'(NUM_EVAL - 1)) ? DONE : RST;
            end
            DONE: begin
               for (int i = 0; i < RESP_W; i++) response[i] <= (vote[i] > HALF_VOTES);
`ifdef BR_PUF_STABILITY_MASK_EN
               for (int i = 0; i < RESP_W; i++)
                  stable_mask[i] <= (vote[i] == '0) || (vote[i] == ALL_VOTES);
`endif
               response_valid <= 1'b1;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_br_puf_reader.sv
// Directed self-checking bench for br_puf_reader with a behavioural ring-array model.
// Define BR_PUF_STABILITY_MASK_EN to also check the stable_mask output.
module tb_br_puf_reader;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [31:0] challenge;
   logic        busy;
   logic [31:0] response;
   logic        response_valid;
   logic [31:0] puf_challenge;
   logic        puf_reset;
   logic [31:0] puf_response;
`ifdef BR_PUF_STABILITY_MASK_EN
   logic [31:0] stable_mask;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model_val [5];
   int          fall_cnt = 0;
   int          base_fall = 0;
   int          model_idx;
   logic        wave_rst  [800];
   logic        wave_busy [800];
   logic [31:0] chal_mid;
   int          valid_cnt;

   br_puf_reader dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .challenge     (challenge),
      .busy          (busy),
      .response      (response),
      .response_valid(response_valid),
      .puf_challenge (puf_challenge),
      .puf_reset     (puf_reset),
      .puf_response  (puf_response)
`ifdef BR_PUF_STABILITY_MASK_EN
      ,
      .stable_mask   (stable_mask)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Ring array model: each falling edge of puf_reset starts a new evaluation.
   always @(negedge puf_reset) fall_cnt++;

   always_comb begin
      model_idx = fall_cnt - base_fall - 1;
      if (model_idx < 0 || model_idx > 4) model_idx = 0;
   end

   assign puf_response = puf_reset ? 32'hFFFF_FFFF : model_val[model_idx];

   task automatic set_model(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                            input logic [31:0] v3, input logic [31:0] v4);
      model_val[0] = v0;
      model_val[1] = v1;
      model_val[2] = v2;
      model_val[3] = v3;
      model_val[4] = v4;
   endtask

   // Issues one request and records per-cycle puf_reset/busy; lat is edges from accept to valid.
   task automatic run_request(input logic [31:0] chal, input int inject_at,
                              input logic [31:0] inject_chal, output int lat);
      int n;
      @(negedge clk);
      challenge = chal;
      start     = 1'b1;
      base_fall = fall_cnt;
      @(posedge clk);
      lat       = -1;
      n         = 0;
      valid_cnt = 0;
      chal_mid  = '0;
      while (n < 800) begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
         if (inject_at > 0 && n == inject_at) begin
            start     = 1'b1;
            challenge = inject_chal;
         end
         if (inject_at > 0 && n == inject_at + 1) start = 1'b0;
         if (inject_at > 0 && n == inject_at + 5) chal_mid = puf_challenge;
         wave_rst[n-1]  = puf_reset;
         wave_busy[n-1] = busy;
         if (response_valid) begin
            valid_cnt++;
            if (lat < 0) lat = n - 1;
         end
         if (lat >= 0 && n >= lat + 4) break;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_busy: got %b expected 0", busy);
      end
      n_checks++;
      if (response !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_response: got %h expected 00000000", response);
      end
      n_checks++;
      if (response_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_valid: got %b expected 0", response_valid);
      end
      n_checks++;
      if (puf_challenge !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_puf_challenge: got %h expected 00000000", puf_challenge);
      end
      n_checks++;
      if (puf_reset !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL reset_puf_reset: got %b expected 1", puf_reset);
      end
`ifdef BR_PUF_STABILITY_MASK_EN
      n_checks++;
      if (stable_mask !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_stable_mask: got %h expected 00000000", stable_mask);
      end
`endif
   endtask

   task automatic test_basic();
      int lat;
      int bad_rst;
      int bad_busy;
      int first_bad;
      logic exp_rst;
      set_model(32'hA5A5_3C3C, 32'hA5A5_3C3C, 32'hA5A5_3C3C, 32'hA5A5_3C3C, 32'hA5A5_3C3C);
      run_request(32'h1234_5678, 0, 32'h0, lat);
      n_checks++;
      if (lat != 366) begin
         n_fail++;
         $display("[TB] FAIL basic_latency: got %0d expected 366", lat);
      end
      n_checks++;
      if (response !== 32'hA5A5_3C3C) begin
         n_fail++;
         $display("[TB] FAIL basic_response: got %h expected a5a53c3c", response);
      end
      n_checks++;
      if (puf_challenge !== 32'h1234_5678) begin
         n_fail++;
         $display("[TB] FAIL basic_puf_challenge: got %h expected 12345678", puf_challenge);
      end
      n_checks++;
      if (valid_cnt != 1) begin
         n_fail++;
         $display("[TB] FAIL basic_valid_pulses: got %0d expected 1", valid_cnt);
      end
      if (lat >= 0) begin
         n_checks++;
         if (wave_busy[lat+1] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL basic_busy_fall: got %b expected 0", wave_busy[lat+1]);
         end
         bad_busy = 0;
         for (int k = 1; k <= lat; k++) if (wave_busy[k] !== 1'b1) bad_busy++;
         n_checks++;
         if (bad_busy != 0) begin
            n_fail++;
            $display("[TB] FAIL basic_busy_high: got %0d low cycles expected 0", bad_busy);
         end
         // 8 high, 65 low per evaluation; high again in DONE and IDLE.
         bad_rst   = 0;
         first_bad = -1;
         for (int k = 0; k <= lat + 2; k++) begin
            exp_rst = (k >= 365) ? 1'b1 : ((k % 73) < 8);
            if (wave_rst[k] !== exp_rst) begin
               bad_rst++;
               if (first_bad < 0) first_bad = k;
            end
         end
         n_checks++;
         if (bad_rst != 0) begin
            n_fail++;
            $display("[TB] FAIL puf_reset_waveform: got %0d wrong cycles (first %0d) expected 0",
                     bad_rst, first_bad);
         end
      end
   endtask

   task automatic test_vote(input string name, input logic [31:0] v0, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [31:0] v3, input logic [31:0] v4,
                            input logic [31:0] exp_resp, input logic [31:0] exp_mask);
      int lat;
      set_model(v0, v1, v2, v3, v4);
      run_request(32'h0000_00C3, 0, 32'h0, lat);
      n_checks++;
      if (response !== exp_resp) begin
         n_fail++;
         $display("[TB] FAIL %s_response: got %h expected %h", name, response, exp_resp);
      end
      n_checks++;
      if (lat != 366) begin
         n_fail++;
         $display("[TB] FAIL %s_latency: got %0d expected 366", name, lat);
      end
`ifdef BR_PUF_STABILITY_MASK_EN
      n_checks++;
      if (stable_mask !== exp_mask) begin
         n_fail++;
         $display("[TB] FAIL %s_stable_mask: got %h expected %h", name, stable_mask, exp_mask);
      end
`else
      if (exp_mask === 32'hx) $display("[TB] note: mask expectation unused");
`endif
   endtask

   task automatic test_back_to_back();
      int lat;
      set_model(32'h0F1E_2D3C, 32'h0F1E_2D3C, 32'h0F1E_2D3C, 32'h0F1E_2D3C, 32'h0F1E_2D3C);
      run_request(32'hCAFE_F00D, 100, 32'h0BAD_0BAD, lat);
      n_checks++;
      if (chal_mid !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("[TB] FAIL ignore_start_mid_challenge: got %h expected cafef00d", chal_mid);
      end
      n_checks++;
      if (puf_challenge !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("[TB] FAIL ignore_start_final_challenge: got %h expected cafef00d", puf_challenge);
      end
      n_checks++;
      if (valid_cnt != 1) begin
         n_fail++;
         $display("[TB] FAIL ignore_start_valid_pulses: got %0d expected 1", valid_cnt);
      end
      n_checks++;
      if (lat != 366 || response !== 32'h0F1E_2D3C) begin
         n_fail++;
         $display("[TB] FAIL ignore_start_result: got lat %0d resp %h expected 366 0f1e2d3c", lat, response);
      end
   endtask

   task automatic test_reset_mid_request();
      int lat;
      int seen_valid;
      int bad_rst;
      set_model(32'h5A5A_0F0F, 32'h5A5A_0F0F, 32'h5A5A_0F0F, 32'h5A5A_0F0F, 32'h5A5A_0F0F);
      @(negedge clk);
      challenge = 32'h7777_0001;
      start     = 1'b1;
      base_fall = fall_cnt;
      @(posedge clk);
      // Cycle 179 after accept lies in the SETTLE window of evaluation 2.
      for (int n = 1; n <= 180; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
      end
      reset_n = 1'b0;
      #1;
      test_reset();
      seen_valid = 0;
      bad_rst    = 0;
      repeat (5) begin
         @(negedge clk);
         if (response_valid) seen_valid++;
         if (puf_reset !== 1'b1) bad_rst++;
      end
      n_checks++;
      if (seen_valid != 0 || bad_rst != 0) begin
         n_fail++;
         $display("[TB] FAIL reset_hold: got %0d valid %0d puf_reset-low expected 0 0", seen_valid, bad_rst);
      end
      reset_n = 1'b1;
      @(negedge clk);
      run_request(32'h7777_0002, 0, 32'h0, lat);
      n_checks++;
      if (lat != 366 || response !== 32'h5A5A_0F0F) begin
         n_fail++;
         $display("[TB] FAIL post_reset_request: got lat %0d resp %h expected 366 5a5a0f0f", lat, response);
      end
      n_checks++;
      if (puf_challenge !== 32'h7777_0002) begin
         n_fail++;
         $display("[TB] FAIL post_reset_challenge: got %h expected 77770002", puf_challenge);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      challenge = '0;
      set_model('0, '0, '0, '0, '0);
      repeat (3) @(negedge clk);
      test_reset();
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      test_basic();
      test_vote("minority", 32'h0, 32'h1, 32'h0, 32'h1, 32'h0, 32'h0, 32'hFFFF_FFFE);
      test_vote("majority", 32'h1, 32'h0, 32'h1, 32'h0, 32'h1, 32'h1, 32'hFFFF_FFFE);
      test_back_to_back();
      test_reset_mid_request();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
